// File: rtl/cci_mpf_prim_fifo_reader.sv
// Drains a show-ahead FIFO into a fixed-depth, non-stalling register pipeline.
// A flush discards FIFO contents until the FIFO is seen empty.
module cci_mpf_prim_fifo_reader #(
  parameter int unsigned N_DATA_BITS = 32,
  parameter int unsigned PIPE_DEPTH  = 2,
  parameter int unsigned CNT_BITS    = 16
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic [N_DATA_BITS-1:0] fifo_first,
  input  logic                   fifo_notEmpty,
  output logic                   fifo_deq,

  output logic [N_DATA_BITS-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_almostFull,

  input  logic                   flush,
  output logic                   flush_done,
  output logic [CNT_BITS-1:0]    n_delivered
);

  if (PIPE_DEPTH < 1 || PIPE_DEPTH > 8) begin : g_bad_depth
    $error("PIPE_DEPTH must be in 1..8");
  end

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t                                   state_q, state_d;
  logic                                     flush_done_q, flush_done_d;
  logic [CNT_BITS-1:0]                      cnt_q, cnt_d;
  logic [PIPE_DEPTH-1:0]                    valid_q, valid_d;
  logic [PIPE_DEPTH-1:0][N_DATA_BITS-1:0]   data_q, data_d;
  logic                                     deliver;

  // Kept to a single gate so the downstream almostFull path stays short.
  assign fifo_deq = fifo_notEmpty && ((state_q == FLUSH) || !out_almostFull);

  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    deliver      = 1'b0;
    unique case (state_q)
      RUN: begin
        deliver = fifo_deq;
        if (flush) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (!fifo_notEmpty) begin
          state_d      = RUN;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    cnt_d = deliver ? cnt_q + CNT_BITS'(1) : cnt_q;

    // Shift by concatenate-and-truncate so PIPE_DEPTH=1 needs no special case.
    valid_d = PIPE_DEPTH'({valid_q, deliver});
    data_d  = (PIPE_DEPTH * N_DATA_BITS)'({data_q, fifo_first});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      flush_done_q <= 1'b0;
      cnt_q        <= '0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      flush_done_q <= flush_done_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign out_valid   = valid_q[PIPE_DEPTH-1];
  assign out_data    = data_q[PIPE_DEPTH-1];
  assign flush_done  = flush_done_q;
  assign n_delivered = cnt_q;

  a_deq_needs_entry: assert property (@(posedge clk) disable iff (reset)
    !(fifo_deq && !fifo_notEmpty))
    else $fatal(1, "fifo_deq asserted with fifo_notEmpty low");

endmodule

// File: tb/tb_cci_mpf_prim_fifo_reader.sv
// Bench for cci_mpf_prim_fifo_reader: an upstream FIFO queue, a delivery
// schedule model keyed by cycle number, table vectors and directed sequences.
module tb_cci_mpf_prim_fifo_reader;

  localparam int P  = 2;
  localparam int CB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fifo_first;
  logic        fifo_notEmpty;
  logic        fifo_deq;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_almostFull;
  logic        flush;
  logic        flush_done;
  logic [CB-1:0] n_delivered;

  cci_mpf_prim_fifo_reader #(
    .N_DATA_BITS (32),
    .PIPE_DEPTH  (P),
    .CNT_BITS    (CB)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fifo_first     (fifo_first),
    .fifo_notEmpty  (fifo_notEmpty),
    .fifo_deq       (fifo_deq),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_almostFull (out_almostFull),
    .flush          (flush),
    .flush_done     (flush_done),
    .n_delivered    (n_delivered)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: upstream FIFO contents, entries scheduled to appear at
  // a given cycle, flush mode, pending done pulse and delivered count.
  logic [31:0] q[$];
  logic [31:0] exp_out [int];
  logic        m_flush;
  logic        m_done;
  int          m_cnt;
  int          cyc;

  logic        s_deq, s_valid, s_done;
  logic [31:0] s_data;
  logic [CB-1:0] s_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic do_reset(input int n);
    reset          = 1'b1;
    fifo_notEmpty  = 1'b0;
    fifo_first     = '0;
    flush          = 1'b0;
    out_almostFull = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_out.delete();
    m_flush = 1'b0;
    m_done  = 1'b0;
    m_cnt   = 0;
  endtask

  // One clock: drive, sample, compare with model, advance.
  task automatic cycle(input logic af, input logic fl);
    logic e_deq;
    logic ne;
    out_almostFull = af;
    flush          = fl;
    ne             = (q.size() > 0);
    fifo_notEmpty  = ne;
    fifo_first     = ne ? q[0] : 32'h0;
    #1;
    s_deq   = fifo_deq;
    s_valid = out_valid;
    s_data  = out_data;
    s_done  = flush_done;
    s_cnt   = n_delivered;
    e_deq   = ne && (m_flush || !af);
    chk("deq", 64'(s_deq), 64'(e_deq));
    chk("out_valid", 64'(s_valid), 64'(exp_out.exists(cyc) ? 1 : 0));
    if (exp_out.exists(cyc)) chk("out_data", 64'(s_data), 64'(exp_out[cyc]));
    chk("flush_done", 64'(s_done), 64'(m_done));
    chk("n_delivered", 64'(s_cnt), 64'(m_cnt % (1 << CB)));
    @(posedge clk);
    #1;
    m_done = m_flush && !ne;
    if (e_deq) begin
      if (!m_flush) begin
        exp_out[cyc + P] = q[0];
        m_cnt++;
      end
      void'(q.pop_front());
    end
    m_flush = m_flush ? ne : fl;
    if (exp_out.exists(cyc)) exp_out.delete(cyc);
    cyc++;
  endtask

  typedef struct {
    logic        fl;
    logic        af;
    logic        deq;
    logic        v;
    logic [31:0] d;
    logic        done;
    logic [CB-1:0] cnt;
  } vec_t;

  vec_t tbl [8];
  logic [31:0] rx[$];
  int beats;

  initial begin
    // Flush with 5 entries, 0xA0 dequeued in the flush cycle.
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 4'd0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 4'd1};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hA0, 1'b0, 4'd1};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 4'd1};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 4'd1};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 4'd1};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 4'd1};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 4'd1};

    cyc = 0;
    do_reset(2);

    // Streaming 0x10..0x17
    for (int i = 0; i < 8; i++) q.push_back(32'h10 + 32'(i));
    for (int c = 0; c <= 10; c++) begin
      cycle(1'b0, 1'b0);
      if (c <= 9) begin
        chk("stream_deq", 64'(s_deq), 64'(c < 8));
        chk("stream_valid", 64'(s_valid), 64'(c >= 2));
        if (c >= 2) chk("stream_data", 64'(s_data), 64'(32'h10 + 32'(c - 2)));
      end else begin
        chk("stream_count", 64'(s_cnt), 64'd8);
      end
    end

    // Backpressure at cycles 3..6
    rx.delete();
    beats = 0;
    for (int i = 0; i < 12; i++) q.push_back(32'h20 + 32'(i));
    for (int c = 0; c < 20; c++) begin
      cycle((c >= 3 && c <= 6), 1'b0);
      if (c >= 3 && c <= 6) begin
        chk("bp_no_deq", 64'(s_deq), 64'd0);
        if (s_valid) beats++;
      end
      if (s_valid) rx.push_back(s_data);
    end
    chk("bp_beats_le_depth", 64'(beats <= P), 64'd1);
    chk("bp_rx_count", 64'(rx.size()), 64'd12);
    for (int i = 0; i < 12 && i < rx.size(); i++)
      chk("bp_order", 64'(rx[i]), 64'(32'h20 + 32'(i)));

    // Table: flush with 5 entries
    do_reset(1);
    for (int i = 0; i < 5; i++) q.push_back(32'hA0 + 32'(i));
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].af, tbl[i].fl);
      chk("tbl_deq", 64'(s_deq), 64'(tbl[i].deq));
      chk("tbl_valid", 64'(s_valid), 64'(tbl[i].v));
      if (tbl[i].v) chk("tbl_data", 64'(s_data), 64'(tbl[i].d));
      chk("tbl_done", 64'(s_done), 64'(tbl[i].done));
      chk("tbl_count", 64'(s_cnt), 64'(tbl[i].cnt));
    end

    // Flush on empty FIFO, repeated flush while in FLUSH
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0, (c <= 1));
      chk("empty_flush_done", 64'(s_done), 64'(c == 2));
    end

    // Counter wrap at 4 bits: 17 deliveries
    do_reset(1);
    for (int i = 0; i < 17; i++) q.push_back(32'h300 + 32'(i));
    for (int c = 0; c < 20; c++) begin
      cycle(1'b0, 1'b0);
      if (c == 16) chk("wrap_count16", 64'(s_cnt), 64'd0);
    end
    chk("wrap_count17", 64'(s_cnt), 64'd1);

    // Reset mid-stream with 2 in the pipeline and a flush pending
    for (int i = 0; i < 6; i++) q.push_back(32'h50 + 32'(i));
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    do_reset(1);
    for (int c = 0; c < 3; c++) begin
      cycle(1'b1, 1'b0);
      chk("rst_valid", 64'(s_valid), 64'd0);
      chk("rst_count", 64'(s_cnt), 64'd0);
      chk("rst_done", 64'(s_done), 64'd0);
      chk("rst_run_state", 64'(s_deq), 64'd0);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      if (q.size() < 12 && $urandom_range(0, 2) != 0) q.push_back($urandom);
      if ($urandom_range(0, 199) == 0) do_reset(1);
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 24) == 0));
    end
    for (int c = 0; c < 20; c++) cycle(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
